// File: rtl/sequenciador_rega.sv
// Irrigation sequencer: sprinkler/drip runs with pause, level-fault handling and tank fill control.
// Optional fill timeout alarm enabled by defining ENCHIMENTO_TIMEOUT_EN.
`timescale 1ns/1ps
module sequenciador_rega #(
    parameter int unsigned DIV_TICK = 50000000,
    parameter int unsigned T_ASP    = 30,
    parameter int unsigned T_GOT    = 60,
    parameter int unsigned T_PAUSA  = 10,
    parameter int unsigned T_ENCH   = 120
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       liga,
    input  logic       H,
    input  logic       M,
    input  logic       L,
    input  logic       Us,
    input  logic       Ua,
    input  logic       T,
    output logic       Bs,
    output logic       Vs,
    output logic       Ve,
    output logic       Al,
    output logic [2:0] estado,
    output logic       ciclo_fim
);

    localparam int unsigned PW    = (DIV_TICK > 1) ? $clog2(DIV_TICK) : 1;
    localparam int unsigned T_M1  = (T_ASP > T_GOT) ? T_ASP : T_GOT;
    localparam int unsigned T_MAX = (T_M1 > T_PAUSA) ? T_M1 : T_PAUSA;
    localparam int unsigned TW    = $clog2(T_MAX + 1);

    typedef enum logic [2:0] {
        OCIOSO      = 3'd0,
        ASPERSAO    = 3'd1,
        GOTEJAMENTO = 3'd2,
        PAUSA       = 3'd3,
        FALHA       = 3'd4
    } estado_t;

    estado_t         state_q, state_d;
    logic [PW-1:0]   presc_q;
    logic [TW-1:0]   run_q, run_d;
    logic            ok_q, ok_d;
    logic            fim_d, fim_q;
    logic            bs_q, vs_q, ve_q, ve_d, al_q, al_d;
    logic            tick_c, erro_c, drip_c, valid_c;

`ifdef ENCHIMENTO_TIMEOUT_EN
    localparam int unsigned FW = $clog2(T_ENCH + 1);
    logic [FW-1:0]   fill_q, fill_d;
    logic            flag_q, flag_d;
`endif

    assign tick_c  = (presc_q == PW'(DIV_TICK - 1));
    assign erro_c  = (H & ~M) | (M & ~L);
    assign drip_c  = T | ~Ua;
    assign valid_c = (state_q <= FALHA);

    assign Bs        = bs_q;
    assign Vs        = vs_q;
    assign Ve        = ve_q;
    assign Al        = al_q;
    assign ciclo_fim = fim_q;
    assign estado    = state_q;

    // Next state, run/pause timer and fault-clear qualifier
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        ok_d    = ok_q;
        fim_d   = 1'b0;
        case (state_q)
            OCIOSO: begin
                run_d = '0;
                if (liga & Us & ~drip_c & M) begin
                    state_d = ASPERSAO;
                end else if (liga & Us & drip_c & L) begin
                    state_d = GOTEJAMENTO;
                end
            end
            ASPERSAO: begin
                if (~liga | ~M) begin
                    state_d = PAUSA;
                    run_d   = '0;
                end else if (tick_c) begin
                    if (run_q == TW'(T_ASP - 1)) begin
                        state_d = PAUSA;
                        run_d   = '0;
                        fim_d   = 1'b1;
                    end else begin
                        run_d = run_q + TW'(1);
                    end
                end
            end
            GOTEJAMENTO: begin
                if (~liga | ~L) begin
                    state_d = PAUSA;
                    run_d   = '0;
                end else if (tick_c) begin
                    if (run_q == TW'(T_GOT - 1)) begin
                        state_d = PAUSA;
                        run_d   = '0;
                        fim_d   = 1'b1;
                    end else begin
                        run_d = run_q + TW'(1);
                    end
                end
            end
            PAUSA: begin
                if (tick_c) begin
                    if (run_q == TW'(T_PAUSA - 1)) begin
                        state_d = OCIOSO;
                        run_d   = '0;
                    end else begin
                        run_d = run_q + TW'(1);
                    end
                end
            end
            FALHA: begin
                if (ok_q) begin
                    state_d = PAUSA;
                    run_d   = '0;
                    ok_d    = 1'b0;
                end else begin
                    ok_d = 1'b1;
                end
            end
            default: begin
                state_d = OCIOSO;
                run_d   = '0;
                ok_d    = 1'b0;
            end
        endcase
        // Level fault wins over every other condition
        if (erro_c && valid_c) begin
            state_d = FALHA;
            fim_d   = 1'b0;
            ok_d    = 1'b0;
        end
    end

    // Inlet valve hysteresis, optional fill timeout and alarm
    always_comb begin
        ve_d = ve_q;
        if (erro_c | H) begin
            ve_d = 1'b0;
        end else if (~M) begin
            ve_d = 1'b1;
        end
        al_d = (state_d == FALHA) | ~L;
`ifdef ENCHIMENTO_TIMEOUT_EN
        fill_d = fill_q;
        flag_d = flag_q;
        if (~ve_q) begin
            fill_d = '0;
        end else if (tick_c) begin
            if (fill_q == FW'(T_ENCH - 1)) begin
                flag_d = 1'b1;
                fill_d = '0;
            end else begin
                fill_d = fill_q + FW'(1);
            end
        end
        if (flag_d) begin
            ve_d = 1'b0;
        end
        al_d = al_d | flag_d;
`endif
        if (state_d == FALHA) begin
            ve_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= OCIOSO;
            presc_q <= '0;
            run_q   <= '0;
            ok_q    <= 1'b0;
            fim_q   <= 1'b0;
            bs_q    <= 1'b0;
            vs_q    <= 1'b0;
            ve_q    <= 1'b0;
            al_q    <= 1'b0;
`ifdef ENCHIMENTO_TIMEOUT_EN
            fill_q  <= '0;
            flag_q  <= 1'b0;
`endif
        end else begin
            presc_q <= tick_c ? '0 : presc_q + PW'(1);
            state_q <= state_d;
            run_q   <= run_d;
            ok_q    <= ok_d;
            fim_q   <= fim_d;
            bs_q    <= (state_d == ASPERSAO);
            vs_q    <= (state_d == GOTEJAMENTO);
            ve_q    <= ve_d;
            al_q    <= al_d;
`ifdef ENCHIMENTO_TIMEOUT_EN
            fill_q  <= fill_d;
            flag_q  <= flag_d;
`endif
        end
    end

endmodule

// File: tb/tb_sequenciador_rega.sv
// Self-checking bench for sequenciador_rega: directed scenarios plus randomized inputs against a reference model.
`timescale 1ns/1ps
module tb_sequenciador_rega;

    localparam int unsigned DIV = 4;
    localparam int unsigned TA  = 3;
    localparam int unsigned TG  = 5;
    localparam int unsigned TP  = 2;
    localparam int unsigned TE  = 6;

    localparam int S_IDLE = 0, S_ASP = 1, S_GOT = 2, S_PAU = 3, S_FAL = 4;

    logic       clock, reset;
    logic       liga, H, M, L, Us, Ua, T;
    logic       Bs, Vs, Ve, Al, ciclo_fim;
    logic [2:0] estado;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int cyc, m_st, m_run, m_ok, m_fill;
    bit m_ve, m_al, m_cf, m_flag;

    int bs_n, vs_n, pa_n, cf_n;

    sequenciador_rega #(
        .DIV_TICK(DIV), .T_ASP(TA), .T_GOT(TG), .T_PAUSA(TP), .T_ENCH(TE)
    ) dut (
        .clock(clock), .reset(reset), .liga(liga), .H(H), .M(M), .L(L),
        .Us(Us), .Ua(Ua), .T(T), .Bs(Bs), .Vs(Vs), .Ve(Ve), .Al(Al),
        .estado(estado), .ciclo_fim(ciclo_fim)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        cyc = 0; m_st = S_IDLE; m_run = 0; m_ok = 0; m_fill = 0;
        m_ve = 0; m_al = 0; m_cf = 0; m_flag = 0;
    endtask

    // One clock of behaviour: ticks are every DIV-th edge counted from reset release
    task automatic model_edge();
        bit tick, erro, nv;
        cyc++;
        tick = (cyc % DIV) == 0;
        erro = (H && !M) || (M && !L);
        m_cf = 0;
        if (erro) begin
            m_st = S_FAL; m_ok = 0;
        end else begin
            case (m_st)
                S_IDLE: if (liga && Us) begin
                    if (T || !Ua) begin
                        if (L) begin m_st = S_GOT; m_run = 0; end
                    end else if (M) begin
                        m_st = S_ASP; m_run = 0;
                    end
                end
                S_ASP: if (!liga || !M) begin m_st = S_PAU; m_run = 0; end
                       else if (tick) begin
                           m_run++;
                           if (m_run == TA) begin m_st = S_PAU; m_run = 0; m_cf = 1; end
                       end
                S_GOT: if (!liga || !L) begin m_st = S_PAU; m_run = 0; end
                       else if (tick) begin
                           m_run++;
                           if (m_run == TG) begin m_st = S_PAU; m_run = 0; m_cf = 1; end
                       end
                S_PAU: if (tick) begin
                           m_run++;
                           if (m_run == TP) begin m_st = S_IDLE; m_run = 0; end
                       end
                S_FAL: begin
                    m_ok++;
                    if (m_ok == 2) begin m_st = S_PAU; m_run = 0; m_ok = 0; end
                end
                default: m_st = S_IDLE;
            endcase
        end
`ifdef ENCHIMENTO_TIMEOUT_EN
        if (!m_ve) m_fill = 0;
        else if (tick) begin
            m_fill++;
            if (m_fill == TE) begin m_flag = 1; m_fill = 0; end
        end
`endif
        nv = m_ve;
        if (erro || H) nv = 0;
        else if (!M) nv = 1;
        if (m_flag) nv = 0;
        if (m_st == S_FAL) nv = 0;
        m_ve = nv;
        m_al = (m_st == S_FAL) || !L || m_flag;
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        check("Bs", Bs, (m_st == S_ASP));
        check("Vs", Vs, (m_st == S_GOT));
        check("Ve", Ve, m_ve);
        check("Al", Al, m_al);
        check("estado", estado, m_st);
        check("ciclo_fim", ciclo_fim, m_cf);
    endtask

    task automatic set_in(input logic li, input logic h, input logic m, input logic l,
                          input logic us, input logic ua, input logic t);
        liga = li; H = h; M = m; L = l; Us = us; Ua = ua; T = t;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("rst_Bs", Bs, 0);
        check("rst_Vs", Vs, 0);
        check("rst_Ve", Ve, 0);
        check("rst_Al", Al, 0);
        check("rst_estado", estado, 0);
        check("rst_ciclo_fim", ciclo_fim, 0);
        @(negedge clock);
        model_reset();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        set_in(0, 1, 1, 1, 0, 1, 0);
        model_reset();

        // Sprinkler run entered on a tick edge
        do_reset();
        set_in(0, 1, 1, 1, 1, 1, 0);
        repeat (3) step();
        liga = 1'b1;
        bs_n = 0; pa_n = 0; cf_n = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            bs_n += int'(Bs);
            pa_n += int'(estado == 3'd3);
            cf_n += int'(ciclo_fim);
            if (estado == 3'd3) liga = 1'b0;
        end
        check("asp_bs_cycles", bs_n, 12);
        check("asp_pausa_cycles", pa_n, 8);
        check("asp_cf_pulses", cf_n, 1);
        check("asp_back_idle", estado, 0);

        // Drip run
        do_reset();
        set_in(0, 0, 0, 1, 1, 1, 1);
        repeat (3) step();
        liga = 1'b1;
        vs_n = 0; bs_n = 0; pa_n = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            vs_n += int'(Vs);
            bs_n += int'(Bs);
            pa_n += int'(estado == 3'd3);
            if (estado == 3'd3) liga = 1'b0;
        end
        check("got_vs_cycles", vs_n, 20);
        check("got_bs_cycles", bs_n, 0);
        check("got_pausa_cycles", pa_n, 8);
        H = 1'b1; M = 1'b1;
        step();
        check("got_ve_clears_on_H", Ve, 0);

        // Early termination on loss of M
        do_reset();
        set_in(1, 1, 1, 1, 1, 1, 0);
        repeat (5) step();
        check("early_in_asp", estado, 1);
        H = 1'b0; M = 1'b0;
        step();
        check("early_bs", Bs, 0);
        check("early_estado", estado, 3);
        check("early_cf", ciclo_fim, 0);

        // Level fault mid-run and its clearing
        do_reset();
        set_in(1, 1, 1, 1, 1, 1, 0);
        repeat (3) step();
        H = 1'b1; M = 1'b0;
        step();
        check("fault_estado", estado, 4);
        check("fault_al", Al, 1);
        check("fault_bs", Bs, 0);
        check("fault_vs", Vs, 0);
        check("fault_ve", Ve, 0);
        M = 1'b1;
        step();
        check("fault_hold", estado, 4);
        step();
        check("fault_clear", estado, 3);

        // Asynchronous reset mid-drip
        do_reset();
        set_in(1, 0, 0, 1, 1, 1, 1);
        repeat (4) step();
        check("mid_rst_in_got", Vs, 1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_vs", Vs, 0);
        check("mid_rst_estado", estado, 0);
        @(negedge clock);
        model_reset();
        reset = 1'b0;

        // Fill with tank low and never reaching high
        do_reset();
        set_in(0, 0, 0, 1, 1, 1, 0);
        repeat (30) step();
`ifdef ENCHIMENTO_TIMEOUT_EN
        check("fill_timeout_ve", Ve, 0);
        check("fill_timeout_al", Al, 1);
`else
        check("fill_no_timeout_ve", Ve, 1);
        check("fill_no_timeout_al", Al, 0);
`endif

        // Randomized inputs, mostly consistent level readings
        do_reset();
        for (int i = 0; i < 500; i++) begin
            int lvl;
            int hold;
            if ($urandom_range(0, 19) < 17) begin
                lvl = int'($urandom_range(0, 3));
                L = (lvl >= 1); M = (lvl >= 2); H = (lvl >= 3);
            end else begin
                H = 1'($urandom); M = 1'($urandom); L = 1'($urandom);
            end
            liga = ($urandom_range(0, 9) < 8);
            Us   = ($urandom_range(0, 9) < 8);
            Ua   = 1'($urandom);
            T    = 1'($urandom);
            hold = int'($urandom_range(1, 20));
            repeat (hold) step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sequenciador_rega.md
SEQUENCIADOR_REGA -- requirements
Module: sequenciador_rega

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- DIV_TICK, 50000000: clock cycles per timing tick.
- T_ASP, 30: sprinkler run length, in ticks.
- T_GOT, 60: drip run length, in ticks.
- T_PAUSA, 10: minimum off time between cycles, in ticks.
- T_ENCH, 120: fill timeout, in ticks.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning); clock and reset come first:
- clock  in  1: single clock; every flop is in this domain.
- reset  in  1: asynchronous, active-high reset.
- liga  in  1: irrigation enable.
- H, M, L  in  1 each: tank high, medium and low level sensors; 1 = water present.
- Us  in  1: soil dry.
- Ua  in  1: air humid.
- T  in  1: temperature high.
- Bs  out  1: sprinkler valve.
- Vs  out  1: drip valve.
- Ve  out  1: tank inlet valve.
- Al  out  1: alarm.
- estado  out  3: FSM state code.
- ciclo_fim  out  1: one-cycle pulse when a run completes.

Function
REQ-003 A free-running prescaler SHALL assert an internal tick for one cycle every DIV_TICK clocks. Every timer SHALL advance only on tick.
REQ-004 The block SHALL decode erro = (H & ~M) | (M & ~L). Critical level SHALL be ~L.
REQ-005 The FSM SHALL have these states and codes: OCIOSO=0, ASPERSAO=1, GOTEJAMENTO=2, PAUSA=3, FALHA=4. Codes 5-7 SHALL recover to OCIOSO on the next clock.
REQ-006 Mode selection: drip SHALL be chosen if T | ~Ua; sprinkler SHALL be chosen otherwise.
REQ-007 Transition OCIOSO->ASPERSAO SHALL occur when liga & Us & sprinkler mode & M.
REQ-008 Transition OCIOSO->GOTEJAMENTO SHALL occur when liga & Us & drip mode & L.
REQ-009 Bs SHALL equal 1 only in ASPERSAO. Vs SHALL equal 1 only in GOTEJAMENTO. Both SHALL be registered outputs.
REQ-010 Run timer behaviour:
- The timer SHALL clear on run entry.
- The run SHALL end after T_ASP or T_GOT ticks, moving to PAUSA with ciclo_fim=1 for one cycle.
REQ-011 Early termination: liga=0, or loss of the required level (M in ASPERSAO, L in GOTEJAMENTO), SHALL move the FSM to PAUSA on the next clock with ciclo_fim=0. Us=0 mid-run SHALL NOT end the run.
REQ-012 PAUSA SHALL last exactly T_PAUSA ticks, then move to OCIOSO. No run SHALL start from PAUSA.
REQ-013 erro=1 SHALL move any state to FALHA on the next clock. Priority SHALL be erro > liga/level > timer expiry.
REQ-014 FALHA SHALL hold Bs=Vs=Ve=0 and Al=1. It SHALL move to PAUSA when erro=0 for 2 consecutive clocks.
REQ-015 Ve hysteresis:
- Ve SHALL set when ~M & ~erro.
- Ve SHALL clear when H | erro.
- Ve SHALL otherwise hold, and SHALL be independent of the FSM except in FALHA.
REQ-016 Al SHALL equal FALHA | (~L), plus the timeout flag when that flag is enabled. Al SHALL be registered.
REQ-017 estado SHALL reflect the current state code with zero latency from the state register.

Reset
REQ-018 Reset assertion SHALL asynchronously force the following: state=OCIOSO; Bs=Vs=Ve=Al=ciclo_fim=0; estado=0; prescaler, all timers and the timeout flag=0.
REQ-019 On reset release, the first tick SHALL occur DIV_TICK clocks later. Reset mid-run SHALL drop the valves immediately with no PAUSA.

Configuration
REQ-020 Macro ENCHIMENTO_TIMEOUT_EN:
- Defined: a fill timer SHALL count ticks while Ve=1 and clear when Ve=0. On reaching T_ENCH, it SHALL set a sticky timeout flag, force Ve=0, and assert Al. The flag SHALL clear only on reset.
- Undefined: there SHALL be no fill timer and no flag. Ve SHALL follow REQ-015 alone.

Verification (DIV_TICK=4, T_ASP=3, T_GOT=5, T_PAUSA=2, T_ENCH=6)
REQ-021 Sprinkler run: liga=1, Us=1, Ua=1, T=0, H=M=L=1 -> Bs=1 for 12 clocks; ciclo_fim pulse; estado=3 for 8 clocks, then 0.
REQ-022 Drip run: T=1, L=1, M=0 -> Vs=1 for 20 clocks and Bs=0 throughout; Ve=1 until H=1.
REQ-023 Early termination: drop M during ASPERSAO -> Bs=0 on the next clock, estado=3, no ciclo_fim.
REQ-024 Fault: H=1, M=0 mid-run -> estado=4, Al=1, Bs=Vs=Ve=0. Clear the fault for 2 clocks -> estado=3.
REQ-025 Reset: assert reset mid-GOTEJAMENTO between clock edges -> Vs=0 and estado=0 before the next edge.
REQ-026 Fill timeout: with ENCHIMENTO_TIMEOUT_EN defined, hold M=H=0 with L=1 -> Ve drops and Al=1 after 24 clocks and stays until reset. With the macro undefined, Ve stays at 1.
